// File: rtl/n_bit_multiplier_with_bcd.sv
// Sequential N x N shift-add multiplier followed by a double-dabble conversion
// of the 2N-bit product into four BCD digits; one multiply per reset release.
module n_bit_multiplier_with_bcd #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic [2*N-1:0]   bin_product,
    output logic [3:0]       BCD_0,
    output logic [3:0]       BCD_1,
    output logic [3:0]       BCD_2,
    output logic [3:0]       BCD_3
);

    localparam int CW = (2 * N > 2) ? $clog2(2 * N) : 1;
    localparam logic [CW-1:0] MULT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(2 * N - 1);

    typedef enum logic [1:0] {LOAD, MULT, CONV, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   sh_q, sh_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [2*N-1:0]   prod_out_q, prod_out_d;
    logic [15:0]      bcd_out_q, bcd_out_d;
    logic             running;
    logic             running_d;

    logic [15:0]      bcd_adj;
    logic [15:0]      bcd_shift;

    // Digits 5..9 become 8..12, so each still fits its nibble before the shift.
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                               : bcd_q[gi*4 +: 4];
    end

    // Dropping bit 15 discards the carry out of the thousands digit (mod 10000).
    assign bcd_shift = {bcd_adj[14:0], sh_q[2*N-1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
        bcd_d      = bcd_q;
        prod_out_d = prod_out_q;
        bcd_out_d  = bcd_out_q;
        running_d  = running;

        unique case (state_q)
            LOAD: begin
                mcand_d   = {{N{1'b0}}, A};
                mplier_d  = B;
                acc_d     = '0;
                cnt_d     = '0;
                bcd_d     = '0;
                running_d = 1'b1;
                state_d   = MULT;
            end
            MULT: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == MULT_LAST) begin
                    cnt_d   = '0;
                    sh_d    = acc_d;
                    bcd_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = bcd_shift;
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CONV_LAST) begin
                    prod_out_d = acc_q;
                    bcd_out_d  = bcd_shift;
                    running_d  = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            sh_q       <= '0;
            bcd_q      <= '0;
            prod_out_q <= '0;
            bcd_out_q  <= '0;
            running    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            bcd_q      <= bcd_d;
            prod_out_q <= prod_out_d;
            bcd_out_q  <= bcd_out_d;
            running    <= running_d;
        end
    end

    assign bin_product = prod_out_q;
    assign BCD_0       = bcd_out_q[3:0];
    assign BCD_1       = bcd_out_q[7:4];
    assign BCD_2       = bcd_out_q[11:8];
    assign BCD_3       = bcd_out_q[15:12];

endmodule

// File: tb/tb_n_bit_multiplier_with_bcd.sv
// Self-checking bench: a cycle-count model of the multiply (plain arithmetic)
// checked every cycle, plus literal expectations for the directed cases.
`timescale 1ns/1ps
module tb_n_bit_multiplier_with_bcd;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  A = 8'd0;
    logic [7:0]  B = 8'd0;
    logic [15:0] bin_product;
    logic [3:0]  BCD_0, BCD_1, BCD_2, BCD_3;

    n_bit_multiplier_with_bcd #(.N(8)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B),
        .bin_product(bin_product),
        .BCD_0(BCD_0), .BCD_1(BCD_1), .BCD_2(BCD_2), .BCD_3(BCD_3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: rising edges since reset release and the operands seen on the first.
    int edge_cnt = 0;
    int m_a = 0;
    int m_b = 0;

    // Literal expectations handed from the stimulus process to the compare process.
    int          lit_req = 0;
    int          lit_ack = 0;
    int          lit_hi = 0;
    int          lit_prod = 0;
    logic [15:0] lit_bcd = 16'd0;

    function automatic int digit_of(input int p, input int k);
        int d;
        d = p % 10000;
        for (int j = 0; j < k; j++) d = d / 10;
        return d % 10;
    endfunction

    always @(posedge clk) begin
        if (reset) edge_cnt = 0;
        else begin
            edge_cnt = edge_cnt + 1;
            if (edge_cnt == 1) begin
                m_a = int'(A);
                m_b = int'(B);
            end
        end
    end

    always @(negedge clk) begin
        int   ep;
        logic er;
        logic [3:0] dig [4];
        dig[0] = BCD_0; dig[1] = BCD_1; dig[2] = BCD_2; dig[3] = BCD_3;
        if (reset || edge_cnt == 0) begin
            ep = 0; er = 1'b0;
        end else begin
            er = (edge_cnt <= 24);
            ep = (edge_cnt >= 25) ? m_a * m_b : 0;
        end
        checks++;
        if (dut.running !== er) begin
            errors++;
            $display("FAIL running t=%0t edge=%0d got=%b want=%b", $time, edge_cnt, dut.running, er);
        end
        checks++;
        if (bin_product !== 16'(ep)) begin
            errors++;
            $display("FAIL bin_product t=%0t got=%0d want=%0d", $time, bin_product, ep);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dig[k] !== 4'(digit_of(ep, k))) begin
                errors++;
                $display("FAIL BCD_%0d t=%0t got=%0d want=%0d", k, $time, dig[k], digit_of(ep, k));
            end
        end
        if (lit_req != lit_ack) begin
            checks++;
            if (lit_hi != 24) begin
                errors++;
                $display("FAIL latency got=%0d cycles want=24", lit_hi);
            end
            checks++;
            if (bin_product !== 16'(lit_prod)) begin
                errors++;
                $display("FAIL lit_product got=%0d want=%0d", bin_product, lit_prod);
            end
            checks++;
            if ({BCD_3, BCD_2, BCD_1, BCD_0} !== lit_bcd) begin
                errors++;
                $display("FAIL lit_bcd got=%h want=%h", {BCD_3, BCD_2, BCD_1, BCD_0}, lit_bcd);
            end
            lit_ack = lit_req;
        end
    end

    task automatic run_case(input logic [7:0] a, input logic [7:0] b, input int ep,
                            input logic [15:0] eb, input bit scramble);
        int hi;
        hi = 0;
        @(negedge clk);
        #1 reset = 1'b1; A = a; B = b;
        @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dut.running === 1'b1) begin
                hi++;
                if (scramble && hi == 2) begin
                    A = 8'($urandom_range(0, 255));
                    B = 8'($urandom_range(0, 255));
                end
            end else if (hi > 0) break;
        end
        $display("mul A=%0d B=%0d running_cycles=%0d product=%0d bcd=%h", a, b, hi,
                 bin_product, {BCD_3, BCD_2, BCD_1, BCD_0});
        lit_hi   = hi;
        lit_prod = ep;
        lit_bcd  = eb;
        lit_req  = lit_req + 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        run_case(8'd12,  8'd11,  132,   16'h0132, 1'b0);
        run_case(8'd25,  8'd4,   100,   16'h0100, 1'b0);
        run_case(8'd255, 8'd1,   255,   16'h0255, 1'b0);
        run_case(8'd0,   8'd128, 0,     16'h0000, 1'b0);
        run_case(8'd255, 8'd255, 65025, 16'h5025, 1'b1);

        // Abort a multiply partway through MULT; the restart must use the new operands.
        @(negedge clk);
        #1 reset = 1'b1; A = 8'd37; B = 8'd201;
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        run_case(8'd99, 8'd77, 7623, 16'h7623, 1'b0);

        for (int i = 0; i < 15; i++) begin
            int a, b, p, d;
            logic [15:0] bv;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            p = a * b;
            d = p % 10000;
            bv = {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
            run_case(8'(a), 8'(b), p, bv, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
